// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame geometry
// and the parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_OVS       = 16;
  localparam int UART_DATA_BITS = 8;

  // Parity bit a transmitter appends for the given data and sense.
  function automatic logic parity_bit(
    input logic [31:0] d,
    input logic        odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset to the idle (high) line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_s1   <= i_rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_rx   = r_s2;
  assign o_fall = r_prev & ~r_s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 / 8+parity+1, OVS-times oversampled.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling per bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS       = UART_OVS,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tick,
  input  logic                 i_rx,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVS);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] C_MID = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] C_END = CW'(OVS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  logic w_rx_s;
  logic w_fall;
  logic w_bit;

  uart_state_e r_state;
  uart_state_e w_state_n;

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pen;
  logic                 r_podd;
  logic                 r_par_bad;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;

  logic w_at;
  logic w_clr;
  logic w_start;
  logic w_shift;
  logic w_par;
  logic w_done;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (i_rx),
    .o_rx   (w_rx_s),
    .o_fall (w_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Samples from the two ticks preceding the current one.
  logic [1:0] r_maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_maj <= 2'b11;
    end else if (i_tick && r_state != ST_IDLE) begin
      r_maj <= {r_maj[0], w_rx_s};
    end
  end

  assign w_bit = (r_maj[0] & r_maj[1]) |
                 (r_maj[0] & w_rx_s) |
                 (r_maj[1] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_comb begin
    w_state_n = r_state;
    w_clr     = 1'b0;
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_par     = 1'b0;
    w_done    = 1'b0;
    w_at      = i_tick &&
                (r_cnt == ((r_state == ST_START) ? C_MID : C_END));
    unique case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_n = ST_START;
          w_clr     = 1'b1;
          w_start   = 1'b1;
        end
      end
      ST_START: begin
        if (w_at) begin
          w_clr     = 1'b1;
          w_state_n = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_at) begin
          w_clr   = 1'b1;
          w_shift = 1'b1;
          if (r_idx == I_LAST) begin
            w_state_n = r_pen ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_at) begin
          w_clr     = 1'b1;
          w_par     = 1'b1;
          w_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is seen.
        if (w_at) begin
          w_clr     = 1'b1;
          w_done    = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_clr) begin
        r_cnt <= '0;
      end else if (i_tick && r_state != ST_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_start) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_shift) begin
        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pen     <= 1'b0;
      r_podd    <= 1'b0;
      r_par_bad <= 1'b0;
    end else if (w_start) begin
      r_pen     <= i_parity_en;
      r_podd    <= i_parity_odd;
      r_par_bad <= 1'b0;
    end else if (w_par) begin
      r_par_bad <= w_bit != parity_bit(32'(r_shift), r_podd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= r_shift;
        r_ferr <= ~w_bit;
        r_perr <= r_pen & r_par_bad;
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from bit slots,
// expectations queued at issue and checked by a monitor on o_valid.
module tb_uart_rx;

  localparam int OVS = 16;
  localparam int DB  = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_tick = 1'b0;
  logic          i_rx;
  logic          i_parity_en;
  logic          i_parity_odd;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tdiv  = 0;

  uart_rx #(.OVS(OVS), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .i_parity_en  (i_parity_en),
    .i_parity_odd (i_parity_odd),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // One tick every fourth clock.
  always @(negedge clk) begin
    tdiv   = (tdiv + 1) % 4;
    i_tick = (tdiv == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && o_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got data %0h expected none",
                 o_data);
      end else begin
        e = q.pop_front();
        chk("data", 32'(o_data), 32'(e.d));
        chk("parity_err", 32'(o_parity_err), 32'(e.pe));
        chk("frame_err", 32'(o_frame_err), 32'(e.fe));
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!i_tick) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Drives one frame slot by slot; glitch inverts each sample slot.
  task automatic send(input logic [7:0] d, input logic pen,
                      input logic podd, input logic pbit,
                      input logic stop, input bit glitch);
    logic [10:0] bits;
    int          nb;
    exp_t        e;
    i_parity_en  = pen;
    i_parity_odd = podd;
    bits = {stop, pbit, d, 1'b0};
    nb   = pen ? 11 : 10;
    if (!pen) bits[9] = stop;
    e.d  = d;
    e.pe = pen && (pbit != ((^d) ^ podd));
    e.fe = !stop;
    q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      for (int s = 1; s <= OVS; s++) begin
        i_rx = bits[b] ^ (glitch && s == OVS / 2);
        if (b == 1 && s == 1) begin
          chk("busy_mid", 32'(o_busy), 32'd1);
          i_parity_en  = 1'($urandom);
          i_parity_odd = 1'($urandom);
        end
        wait_tick();
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       pen, podd, pbit, stop;
    rst_n        = 1'b0;
    i_rx         = 1'b1;
    i_parity_en  = 1'b0;
    i_parity_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_perr", 32'(o_parity_err), 32'd0);
    chk("rst_ferr", 32'(o_frame_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    idle(4);

    send(8'hA5, 0, 0, 0, 1, 0);
    idle(4);
    chk("busy_idle", 32'(o_busy), 32'd0);

    send(8'h3C, 1, 0, 0, 1, 0);
    send(8'h3C, 1, 0, 1, 1, 0);
    send(8'h01, 1, 1, 0, 1, 0);
    idle(4);

    i_rx = 1'b0;
    repeat (5) wait_tick();
    idle(20);
    chk("glitch_busy", 32'(o_busy), 32'd0);
    send(8'h5A, 0, 0, 0, 1, 0);

    send(8'h81, 0, 0, 0, 0, 0);
    i_rx = 1'b0;
    repeat (3 * 10 * OVS) wait_tick();
    chk("break_busy", 32'(o_busy), 32'd0);
    idle(OVS);
    send(8'h7E, 0, 0, 0, 1, 0);

    send(8'h55, 0, 0, 0, 1, 0);
    send(8'hAA, 0, 0, 0, 1, 0);
    idle(8);

    i_parity_en = 1'b0;
    d = 8'hC3;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < OVS; s++) begin
        i_rx = (b == 0) ? 1'b0 : d[b-1];
        wait_tick();
      end
    end
    rst_n = 1'b0;
    i_rx  = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data", 32'(o_data), 32'd0);
    chk("arst_perr", 32'(o_parity_err), 32'd0);
    chk("arst_ferr", 32'(o_frame_err), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(OVS);
    send(8'hC3, 0, 0, 0, 1, GL);

    for (int k = 0; k < 30; k++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = ((^d) ^ podd) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      send(d, pen, podd, pbit, stop, 0);
      idle(stop ? $urandom_range(0, 3) : $urandom_range(2, 4));
    end

    idle(OVS);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
